dtw_accel_m00_axis: RTL and testbench
=====================================

// Module: dtw_accel_m00_axis
// PURPOSE
//  AXI4-Stream master (source) returning HARU DTW results to the host DMA.
//  The DTW core pushes result words into an internal FIFO; this block drains it onto M_AXIS_*.
//  Framing: TLAST after PACKET_WORDS beats, or on a word tagged last by the DTW core.
//  Companion of the S00 sink: sink feeds DTW, this block returns DTW output.
// PARAMETERS
//  C_M_AXIS_TDATA_WIDTH  32  stream/result word width (multiple of 8)
//  FIFO_DEPTH            16  result FIFO entries (power of 2, >=2)
//  PACKET_WORDS          8   beats per packet unless cut short by dtw_res_last (>=1)
//  C_M_START_COUNT       32  cycles TVALID is held low after reset (>=1)
// PORTS
//  M_AXIS_ACLK       in   1     single clock for the whole block
//  M_AXIS_ARESET     in   1     reset; synchronous, active-high
//  dtw_res_wren      in   1     DTW result write strobe
//  dtw_res_din       in   W     result word (W = C_M_AXIS_TDATA_WIDTH)
//  dtw_res_last      in   1     word closes current packet
//  dtw_res_full      out  1     FIFO full; writes ignored while high
//  dtw_res_overflow  out  1     1-cycle pulse: write attempted while full
//  pkt_count         out  16    packets completed (TLAST handshakes), wraps
//  M_AXIS_TVALID     out  1     beat valid
//  M_AXIS_TDATA      out  W     beat data
//  M_AXIS_TSTRB      out  W/8   byte qualifier, constant all ones
//  M_AXIS_TLAST      out  1     last beat of packet
//  M_AXIS_TREADY     in   1     downstream ready
// BEHAVIOUR
//  Reset (M_AXIS_ARESET=1 at an edge): state=IDLE; FIFO count/pointers=0;
//   TVALID=0, TDATA=0, TLAST=0, beat_cnt=0, pkt_count=0, dtw_res_full=0, dtw_res_overflow=0.
//   Reset mid-packet drops the in-flight beat and all FIFO contents; no TLAST is emitted.
//  FSM: IDLE -> INIT (next edge, unconditionally).
//   INIT counts C_M_START_COUNT cycles -> SEND. SEND holds until reset.
//   TVALID=0 outside SEND. Writes are accepted in every state.
//  FIFO: entries {last,data}, width W+1.
//   Write accepted iff dtw_res_wren && !dtw_res_full.
//   dtw_res_full = (count==FIFO_DEPTH), from registered count.
//   Write while full is dropped; dtw_res_overflow=1 on the following cycle only.
//   Read occurs when output register loads; write+read same edge leaves count unchanged.
//   Pointers wrap FIFO_DEPTH-1 -> 0.
//  Output register: loads the FIFO head at an edge when state==SEND && count!=0
//   && (!TVALID || TREADY).
//   Otherwise, when TVALID && TREADY, TVALID clears to 0.
//   While TVALID && !TREADY: TDATA, TLAST and TVALID are held stable (AXIS rule).
//   Back-to-back beats at 1/cycle while FIFO non-empty and TREADY=1.
//  Latency: a word written at edge k (FIFO empty, register free, SEND) gives TVALID=1 after edge k+1.
//  TLAST on loaded beat = entry.last || (beat_cnt==PACKET_WORDS-1).
//   beat_cnt increments on each TVALID&&TREADY handshake; resets to 0 on the TLAST handshake.
//   pkt_count increments on the TLAST handshake.
//   PACKET_WORDS=1: every beat has TLAST.
//  beat_cnt width clogb2(PACKET_WORDS); count width clogb2(FIFO_DEPTH)+1.
// TESTING
//  1 Reset then TREADY=1, write 0x11..0x18 during INIT -> no TVALID before 32 cycles;
//    then 8 consecutive beats 0x11..0x18, TLAST only on 0x18, pkt_count=1.
//  2 Write 3 words, last tagged on the 3rd, TREADY=1 -> 3 beats, TLAST on 3rd;
//    next 8 words -> TLAST on 8th beat; pkt_count=2.
//  3 TREADY toggling 1/0 randomly with 20 words -> TDATA/TLAST stable while stalled,
//    order preserved, no loss, no duplication.
//  4 TREADY=0 in SEND, write 18 words -> 16 FIFO + 1 output accepted (full after 17th),
//    18th dropped, one overflow pulse, dtw_res_full=1.
//  5 Write and drain on the same edge at count==16 -> the write is dropped, count goes 16->15.
//    At count==5, simultaneous write+read -> count stays 5; pointer wrap after 16 writes keeps data ordered.
//  6 Assert M_AXIS_ARESET mid-packet (beat 4 stalled) -> next cycle TVALID=0, TLAST=0,
//    pkt_count=0; FSM restarts via IDLE/INIT; old data never appears.

Source files
------------

// File: rtl/dtw_accel_m00_axis_if.sv
// AXI4-Stream bundle between the DTW result source and its downstream sink.
interface dtw_accel_m00_axis_if #(
  parameter int unsigned DataWidth = 32
) ();
  logic                   tvalid;
  logic [DataWidth-1:0]   tdata;
  logic [DataWidth/8-1:0] tstrb;
  logic                   tlast;
  logic                   tready;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/dtw_accel_m00_axis.sv
// AXI4-Stream master draining the DTW result FIFO to the host DMA, with TLAST framing
// every PACKET_WORDS beats or on a word tagged last by the DTW core.
module dtw_accel_m00_axis #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH           = 16,
  parameter int unsigned PACKET_WORDS         = 8,
  parameter int unsigned C_M_START_COUNT      = 32
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESET,
  input  logic                            dtw_res_wren,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] dtw_res_din,
  input  logic                            dtw_res_last,
  output logic                            dtw_res_full,
  output logic                            dtw_res_overflow,
  output logic [15:0]                     pkt_count,
  dtw_accel_m00_axis_if.master            m_axis
);

  localparam int unsigned W      = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned BeatW  = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
  localparam int unsigned StartW = (C_M_START_COUNT > 1) ? $clog2(C_M_START_COUNT) : 1;

  typedef enum logic [1:0] {StIdle, StInit, StSend} state_e;

  state_e            state_q, state_d;
  logic [StartW-1:0] start_cnt_q, start_cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [BeatW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [W-1:0]      tdata_q, tdata_d;
  logic              overflow_q, overflow_d;

  // Entry layout: {last, data}.
  logic [W:0] mem_q [FIFO_DEPTH];
  logic [W:0] head;
  logic       wr_en, load, hs;

  assign dtw_res_full = (count_q == CntW'(FIFO_DEPTH));
  assign wr_en        = dtw_res_wren && !dtw_res_full;
  assign hs           = tvalid_q && m_axis.tready;
  assign load         = (state_q == StSend) && (count_q != '0) && (!tvalid_q || m_axis.tready);
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_count_d = pkt_count_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    overflow_d  = dtw_res_wren && dtw_res_full;

    unique case (state_q)
      StIdle: begin
        state_d     = StInit;
        start_cnt_d = '0;
      end
      StInit: begin
        if (start_cnt_q == StartW'(C_M_START_COUNT - 1)) state_d = StSend;
        else start_cnt_d = start_cnt_q + StartW'(1);
      end
      StSend:  state_d = StSend;
      default: state_d = StIdle;
    endcase

    if (hs) begin
      if (tlast_q) begin
        beat_cnt_d  = '0;
        pkt_count_d = pkt_count_q + 16'd1;
      end else begin
        beat_cnt_d  = beat_cnt_q + BeatW'(1);
      end
    end

    // beat_cnt_d already reflects a concurrent handshake, so it is the new beat's index.
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = head[W-1:0];
      tlast_d  = head[W] || (beat_cnt_d == BeatW'(PACKET_WORDS - 1));
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end else if (hs) begin
      tvalid_d = 1'b0;
    end

    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(wr_en) - CntW'(load);
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q     <= StIdle;
      start_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_count_q <= pkt_count_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= {dtw_res_last, dtw_res_din};
  end

  assign m_axis.tvalid    = tvalid_q;
  assign m_axis.tdata     = tdata_q;
  assign m_axis.tlast     = tlast_q;
  assign m_axis.tstrb     = '1;
  assign dtw_res_overflow = overflow_q;
  assign pkt_count        = pkt_count_q;

endmodule

// File: tb/tb_dtw_accel_m00_axis.sv
// Directed + randomized bench for dtw_accel_m00_axis against a queue-based framing model.
module tb_dtw_accel_m00_axis;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int PW    = 8;
  localparam int START = 32;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         wren = 1'b0;
  logic [W-1:0] din = '0;
  logic         last = 1'b0;
  logic         full, ovf;
  logic [15:0]  pkt_count;

  dtw_accel_m00_axis_if #(.DataWidth(W)) axis ();

  dtw_accel_m00_axis #(
    .C_M_AXIS_TDATA_WIDTH(W),
    .FIFO_DEPTH(DEPTH),
    .PACKET_WORDS(PW),
    .C_M_START_COUNT(START)
  ) dut (
    .M_AXIS_ACLK(clk),
    .M_AXIS_ARESET(areset),
    .dtw_res_wren(wren),
    .dtw_res_din(din),
    .dtw_res_last(last),
    .dtw_res_full(full),
    .dtw_res_overflow(ovf),
    .pkt_count(pkt_count),
    .m_axis(axis)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];
  int           pos = 0;
  int           exp_pkts = 0;
  logic         exp_ovf = 1'b0;
  logic         stalled = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;
  int           hs_cnt = 0;
  int           cyc_n = 0;
  int           first_hs = -1;
  int           last_hs = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive inputs for the next posedge, score the beat it will transfer.
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic l, input logic r,
                     input logic acc);
    logic [W:0] e;
    logic       el;
    wren = w; din = d; last = l; axis.tready = r;
    if (stalled) begin
      check("stall_valid", axis.tvalid, 1);
      check("stall_data", axis.tdata, prev_data);
      check("stall_last", axis.tlast, prev_last);
    end
    check("overflow", ovf, exp_ovf);
    if (axis.tvalid && r) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        el = e[W] || (pos == PW - 1);
        check("beat_data", axis.tdata, e[W-1:0]);
        check("beat_last", axis.tlast, el);
        if (el) begin pos = 0; exp_pkts++; end
        else pos++;
        hs_cnt++;
        if (hs_cnt == 1) first_hs = cyc_n;
        last_hs = cyc_n;
      end
    end
    stalled   = axis.tvalid && !r;
    prev_data = axis.tdata;
    prev_last = axis.tlast;
    exp_ovf   = w && !acc;
    if (w && acc) exp_q.push_back({l, d});
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    areset = 1'b1; wren = 1'b0; din = '0; last = 1'b0;
    @(negedge clk);
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tlast", axis.tlast, 0);
    check("rst_tdata", axis.tdata, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_full", full, 0);
    check("rst_overflow", ovf, 0);
    exp_q.delete();
    pos = 0; exp_pkts = 0; exp_ovf = 1'b0; stalled = 1'b0;
    hs_cnt = 0; cyc_n = 0; first_hs = -1; last_hs = -1;
    areset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || axis.tvalid) && n < budget) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
      n++;
    end
    check("drain_in_budget", n < budget, 1);
  endtask

  initial begin
    int           written;
    logic         w, r, l;
    logic [W-1:0] d;
    axis.tready = 1'b0;
    @(negedge clk);
    do_reset();

    // 1: start-up hold-off, then one full packet at one beat per cycle.
    for (int i = 0; i < START; i++) begin
      check("init_tvalid_low", axis.tvalid, 0);
      cyc(i < 8, W'(32'h11 + i), 1'b0, 1'b1, 1'b1);
    end
    drain(40);
    check("first_beat_cycle", first_hs, START + 2);
    check("back_to_back", last_hs - first_hs, 7);
    check("tstrb", axis.tstrb, 4'hf);
    check("pkt_count_t1", pkt_count, exp_pkts);

    // 2: early cut by the last tag, then a full-length packet.
    cyc(1'b1, 32'h21, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 32'h22, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 32'h23, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(32'h31 + i), 1'b0, 1'b1, 1'b1);
    drain(40);
    check("pkt_count_t2", pkt_count, exp_pkts);

    // 3: random writes, tags and backpressure.
    written = 0;
    while (written < 20) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = $urandom;
      l = ($urandom_range(0, 7) == 0);
      cyc(w, d, l, r, 1'b1);
      if (w) written++;
    end
    drain(100);
    check("pkt_count_t3", pkt_count, exp_pkts);
    check("full_low_t3", full, 0);

    // 4: fill under stall; 17 words fit, the 18th overflows.
    for (int i = 0; i < 18; i++) cyc(1'b1, W'(32'h400 + i), 1'b0, 1'b0, i < 17);
    check("full_t4", full, 1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("full_held_t4", full, 1);

    // 5: write while full and draining is dropped; write+read at count 5 keeps order.
    cyc(1'b1, 32'h500, 1'b0, 1'b1, 1'b0);
    check("full_after_drain", full, 0);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 32'h501, 1'b0, 1'b1, 1'b1);
    drain(60);
    check("pkt_count_t5", pkt_count, exp_pkts);

    // 6: reset with the fourth beat of a packet stalled.
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(32'h600 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("stalled_before_reset", axis.tvalid, 1);
    do_reset();
    for (int i = 0; i < START; i++) begin
      check("reinit_tvalid_low", axis.tvalid, 0);
      cyc(i < 3, W'(32'h700 + i), i == 2, 1'b1, 1'b1);
    end
    drain(40);
    check("pkt_count_t6", pkt_count, exp_pkts);
    check("pkt_count_t6_val", pkt_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
